// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - EX/MEM and MEM/WB pipeline registers with data RAM and status register
module mem_wb_stage #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] F,
  input  logic [31:0] data,
  input  logic        MW,
  input  logic        RW,
  input  logic [4:0]  DA,
  input  logic [1:0]  MD,
  input  logic        SE,
  input  logic        V,
  input  logic        C,
  input  logic        N,
  input  logic        Z,
  input  logic        NXORV,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] BUS_D,
  output logic [4:0]  DA_WB,
  output logic        RW_WB,
  output logic [4:0]  DA_MEM,
  output logic        RW_MEM,
  output logic [3:0]  STATUS
);

  // stage 1 (EX/MEM) registers
  logic [31:0] f1;
  logic [31:0] data1;
  logic        mw1;
  logic        rw1;
  logic [4:0]  da1;
  logic [1:0]  md1;
  logic        nxorv1;
  logic        z1;

  // stage 2 (MEM/WB) registers
  logic [31:0] f2;
  logic        rw2;
  logic [4:0]  da2;
  logic [1:0]  md2;
  logic        nxorv2;
  logic        z2;
  logic [31:0] rdata;

  logic [3:0]  status;

  // data memory; upper bits of the EX result are ignored when forming the word address
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] addr1;

  assign addr1 = f1[AW-1:0];

  // capture EX results; a flush turns the slot into a bubble by killing its write enables
  always_ff @(posedge clk) begin
    if (!reset) begin
      f1     <= '0;
      data1  <= '0;
      mw1    <= 1'b0;
      rw1    <= 1'b0;
      da1    <= '0;
      md1    <= '0;
      nxorv1 <= 1'b0;
      z1     <= 1'b0;
    end else if (!stall) begin
      f1     <= F;
      data1  <= data;
      mw1    <= MW & ~flush;
      rw1    <= RW & ~flush;
      da1    <= DA;
      md1    <= MD;
      nxorv1 <= NXORV;
      z1     <= Z;
    end
  end

  // status flags follow the instruction being captured unless it is stalled or flushed
  always_ff @(posedge clk) begin
    if (!reset) begin
      status <= '0;
    end else if (!stall && !flush && SE) begin
      status <= {V, C, N, Z};
    end
  end

  // advance stage 1 into stage 2; the read uses the pre-write RAM word (read-before-write)
  always_ff @(posedge clk) begin
    if (!reset) begin
      f2     <= '0;
      rw2    <= 1'b0;
      da2    <= '0;
      md2    <= '0;
      nxorv2 <= 1'b0;
      z2     <= 1'b0;
      rdata  <= '0;
    end else if (!stall) begin
      f2     <= f1;
      rw2    <= rw1;
      da2    <= da1;
      md2    <= md1;
      nxorv2 <= nxorv1;
      z2     <= z1;
      rdata  <= mem[addr1];
    end
  end

  // commit stores from stage 1; contents survive reset but a pending store is dropped
  always_ff @(posedge clk) begin
    if (reset && !stall && mw1) begin
      mem[addr1] <= data1;
    end
  end

  // write-back select
  always_comb begin
    BUS_D = f2;
    case (md2)
      2'b00:   BUS_D = f2;
      2'b01:   BUS_D = rdata;
      2'b10:   BUS_D = {31'b0, nxorv2};
      default: BUS_D = {31'b0, z2};
    endcase
  end

  assign DA_WB  = da2;
  assign RW_WB  = rw2;
  assign DA_MEM = da1;
  assign RW_MEM = rw1;
  assign STATUS = status;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - randomized and directed checks of mem_wb_stage against a transaction model
module tb_mem_wb_stage;

  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] F;
  logic [31:0] data;
  logic        MW, RW, SE, V, C, N, Z, NXORV, stall, flush;
  logic [4:0]  DA;
  logic [1:0]  MD;
  logic [31:0] BUS_D;
  logic [4:0]  DA_WB, DA_MEM;
  logic        RW_WB, RW_MEM;
  logic [3:0]  STATUS;

  int checks = 0;
  int errors = 0;

  mem_wb_stage #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .F(F), .data(data), .MW(MW), .RW(RW), .DA(DA), .MD(MD),
    .SE(SE), .V(V), .C(C), .N(N), .Z(Z), .NXORV(NXORV), .stall(stall), .flush(flush),
    .BUS_D(BUS_D), .DA_WB(DA_WB), .RW_WB(RW_WB), .DA_MEM(DA_MEM), .RW_MEM(RW_MEM),
    .STATUS(STATUS)
  );

  always #5 clk = ~clk;

  // reference model: memory image, the instruction waiting in the memory slot,
  // and the finished write-back result of the instruction ahead of it
  logic [31:0] m_mem [DEPTH];
  logic [31:0] p_f, p_data;
  logic        p_mw, p_rw, p_nx, p_z;
  logic [4:0]  p_da;
  logic [1:0]  p_md;
  logic [31:0] w_val;
  logic        w_rw;
  logic [4:0]  w_da;
  logic [3:0]  m_status;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    p_f = '0; p_data = '0; p_mw = 0; p_rw = 0; p_nx = 0; p_z = 0; p_da = '0; p_md = '0;
    w_val = '0; w_rw = 0; w_da = '0; m_status = '0;
  endtask

  task automatic model_edge();
    int a;
    logic [31:0] v;
    if (!reset) begin
      model_clear();
    end else if (!stall) begin
      a = int'(p_f % DEPTH);
      if (p_md == 2'd0)      v = p_f;
      else if (p_md == 2'd1) v = m_mem[a];
      else if (p_md == 2'd2) v = 32'(p_nx);
      else                   v = 32'(p_z);
      if (p_mw) m_mem[a] = p_data;
      w_val = v; w_rw = p_rw; w_da = p_da;
      p_f = F; p_data = data; p_da = DA; p_md = MD; p_nx = NXORV; p_z = Z;
      p_mw = MW && !flush;
      p_rw = RW && !flush;
      if (SE && !flush) m_status = {V, C, N, Z};
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("bus_d",  BUS_D,          w_val);
    check("da_wb",  32'(DA_WB),     32'(w_da));
    check("rw_wb",  32'(RW_WB),     32'(w_rw));
    check("da_mem", 32'(DA_MEM),    32'(p_da));
    check("rw_mem", 32'(RW_MEM),    32'(p_rw));
    check("status", 32'(STATUS),    32'(m_status));
  endtask

  task automatic idle();
    reset = 1; F = '0; data = '0; MW = 0; RW = 0; DA = '0; MD = '0; SE = 0;
    V = 0; C = 0; N = 0; Z = 0; NXORV = 0; stall = 0; flush = 0;
  endtask

  task automatic rand_inputs();
    F = $urandom; data = $urandom; MW = 1'($urandom); RW = 1'($urandom);
    DA = 5'($urandom); MD = 2'($urandom); SE = 1'($urandom);
    V = 1'($urandom); C = 1'($urandom); N = 1'($urandom); Z = 1'($urandom);
    NXORV = 1'($urandom); stall = 0; flush = 0;
    if ($urandom_range(0, 1) == 1) F[7:0] = 8'($urandom_range(0, 7));
  endtask

  task automatic drive_load(input logic [31:0] addr);
    idle(); F = addr; MD = 2'b01; RW = 1; DA = 5'd9; step();
    idle(); step();
  endtask

  logic [31:0] prior;
  logic [31:0] frz_bus;
  logic [3:0]  frz_st;

  initial begin
    model_clear();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

    // reset with random inputs
    rand_inputs(); reset = 0; step();
    rand_inputs(); reset = 0; step();
    check("rst_bus_d",  BUS_D,         32'h0);
    check("rst_rw_wb",  32'(RW_WB),    32'h0);
    check("rst_status", 32'(STATUS),   32'h0);
    idle(); F = 32'h5; RW = 1; DA = 5'd3; step();
    idle(); step();
    check("first_bus_d", BUS_D,      32'h5);
    check("first_da_wb", 32'(DA_WB), 32'd3);
    check("first_rw_wb", 32'(RW_WB), 32'd1);

    // fill every RAM word so all later loads have a known value
    for (int i = 0; i < DEPTH; i++) begin
      idle(); F = 32'(i); data = $urandom; MW = 1; step();
    end
    idle(); step();

    // store then back-to-back load, then an aliased load
    idle(); F = 32'h10; data = 32'hDEADBEEF; MW = 1; step();
    drive_load(32'h10);
    check("st_ld", BUS_D, 32'hDEADBEEF);
    drive_load(32'h110);
    check("wrap_ld", BUS_D, 32'hDEADBEEF);

    // status register and set-less-than select
    idle(); SE = 1; V = 1; C = 0; N = 1; Z = 0; step();
    check("status_set", 32'(STATUS), 32'hA);
    idle(); SE = 0; V = 0; C = 1; N = 0; Z = 1; step();
    check("status_hold", 32'(STATUS), 32'hA);
    idle(); MD = 2'b10; NXORV = 1; RW = 1; step();
    idle(); step();
    check("nxorv_sel", BUS_D, 32'h1);

    // stall with a store held in the memory slot
    idle(); F = 32'h20; data = 32'h12345678; MW = 1; RW = 1; DA = 5'd4; step();
    frz_bus = BUS_D; frz_st = STATUS;
    for (int i = 0; i < 3; i++) begin
      rand_inputs(); stall = 1; flush = 1'($urandom); step();
      check("stall_bus_d",  BUS_D,          frz_bus);
      check("stall_status", 32'(STATUS),    32'(frz_st));
      check("stall_rw_mem", 32'(RW_MEM),    32'd1);
    end
    idle(); step();
    drive_load(32'h20);
    check("stall_commit", BUS_D, 32'h12345678);

    // flushed store leaves RAM and write-back untouched
    prior = m_mem[32'h30];
    idle(); F = 32'h30; data = 32'hFFFFFFFF; MW = 1; RW = 1; DA = 5'd6; flush = 1; step();
    check("flush_rw_mem", 32'(RW_MEM), 32'd0);
    idle(); step();
    check("flush_rw_wb", 32'(RW_WB), 32'd0);
    drive_load(32'h30);
    check("flush_mem", BUS_D, prior);

    // flush while stalled has no effect
    idle(); F = 32'h44; RW = 1; DA = 5'd7; step();
    idle(); stall = 1; flush = 1; step();
    check("sf_rw_mem", 32'(RW_MEM), 32'd1);
    check("sf_da_mem", 32'(DA_MEM), 32'd7);
    idle(); step();
    check("sf_rw_wb", 32'(RW_WB), 32'd1);
    check("sf_da_wb", 32'(DA_WB), 32'd7);

    // reset while a store waits in the memory slot
    prior = m_mem[32'h50];
    idle(); F = 32'h50; data = ~prior; MW = 1; RW = 1; DA = 5'd2; SE = 1; V = 1; step();
    idle(); reset = 0; step();
    check("mrst_bus_d",  BUS_D,          32'h0);
    check("mrst_rw_mem", 32'(RW_MEM),    32'h0);
    check("mrst_status", 32'(STATUS),    32'h0);
    drive_load(32'h50);
    check("mrst_mem", BUS_D, prior);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 7) == 0);
      reset = !($urandom_range(0, 63) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Downstream neighbour of the EX stage. Consumes EX results (F, store data, MW, status flags) together with the destination and write-back controls that travel alongside them.
- Performs the data-memory access into an internal synchronous RAM, holds the processor status register, and presents the selected write-back value to the register file two clock edges after capture.
- Provides stall (hold) and flush (bubble) controls for the hazard unit.

Parameters:
- DEPTH, 256, data-memory depth in 32-bit words; must be a power of two.
- AW, 8, address width; equals log2(DEPTH). The word address is F[AW-1:0], and F[31:AW] is ignored.

Ports:
- clk  in  1  clock; rising edge.
- reset  in  1  synchronous active-low reset.
- F  in  32  EX result; the memory word address for loads and stores.
- data  in  32  store data from EX.
- MW  in  1  memory write enable.
- RW  in  1  register-file write enable.
- DA  in  5  destination register.
- MD  in  2  write-back select: 00 = F, 01 = memory, 10 = {31'b0,NXORV}, 11 = {31'b0,Z}.
- SE  in  1  status-register update enable.
- V, C, N, Z, NXORV  in  1 each  EX status flags.
- stall  in  1  hold both stages.
- flush  in  1  turn the instruction currently being captured into a bubble.
- BUS_D  out  32  write-back data.
- DA_WB  out  5  destination register at write-back.
- RW_WB  out  1  register-file write enable at write-back.
- DA_MEM  out  5  stage-1 destination register, for forwarding.
- RW_MEM  out  1  stage-1 write enable, for forwarding.
- STATUS  out  4  status register {V,C,N,Z}.

Behaviour:
- Reset (reset==0 at a clock edge):
  - All stage-1 and stage-2 registers, the read-data register and STATUS clear to 0.
  - BUS_D=0, RW_WB=0, RW_MEM=0, DA_WB=0, DA_MEM=0.
  - RAM contents are not cleared.
  - Any write pending in stage 1 is dropped.
  - Reset overrides stall and flush.
- Stage 1 (EX/MEM register), at each edge with reset=1 and stall=0:
  - Captures F, data, MW, RW, DA, MD, NXORV and Z.
  - If flush=1, captured MW and RW are forced to 0; the other fields are don't-care.
- Status register:
  - Updates at the same capture edge as stage 1 when SE=1, stall=0 and flush=0.
  - Otherwise holds.
- Stage 2 (memory access and MEM/WB register), at each edge with reset=1 and stall=0:
  - If stage-1 MW=1, RAM[F1[AW-1:0]] <= data1.
  - The read-data register takes RAM[F1[AW-1:0]] in read-before-write fashion: a read and write to the same address in the same cycle return the old word.
  - F1, RW1, DA1, MD1, NXORV1 and Z1 move into the stage-2 registers.
- BUS_D is combinational from the stage-2 registers using the MD encoding above; memory data comes from the read-data register.
- Latency: inputs sampled at edge k appear on BUS_D, DA_WB and RW_WB after edge k+1, i.e. 2 cycles. Throughput is one instruction per cycle.
- stall=1:
  - Every register holds: stage 1, stage 2, read data and STATUS.
  - RAM writes are suppressed.
  - flush is ignored while stall=1.
- Back-to-back store then load to the same address: the load, one cycle behind, reads the newly stored word.
- Address wrap: F=DEPTH+3 accesses word 3.
- Bubble propagation: a flushed slot emerges at write-back with RW_WB=0 and causes no RAM write.

Test Plan:
- Reset: hold reset=0 for 2 edges with random inputs -> BUS_D=0, RW_WB=0, STATUS=0. Release, drive F=32'h5, MD=00, RW=1, DA=3 -> two edges later BUS_D=32'h5, DA_WB=3, RW_WB=1.
- Store/load: store (MW=1, F=32'h10, data=32'hDEADBEEF), next cycle load (MW=0, F=32'h10, MD=01) -> BUS_D=32'hDEADBEEF two edges after the load is sampled. A load of F=32'h110 (wraps to word 0x10 with DEPTH=256) returns the same word.
- Status and set-less-than: SE=1 with V=1,C=0,N=1,Z=0 -> STATUS=4'b1010 after one edge. A following cycle with SE=0 and different flags leaves STATUS=4'b1010. MD=10 with NXORV=1 -> BUS_D=32'h1.
- Stall: stall=1 for 3 cycles while a store to F=32'h20 with data=32'h12345678 sits in stage 1 and the inputs change -> outputs frozen and RAM word 0x20 unchanged. After stall drops, the store commits; a later load of 0x20 returns 32'h12345678.
- Flush: flush=1 on a store (F=32'h30, data=32'hFFFFFFFF) with RW=1 -> RW_MEM=0, then RW_WB=0, and a later load of 0x30 returns the prior contents. flush and stall high together -> the stall holds and the flush has no effect.
- Mid-operation reset: reset=0 for one edge while a store is in stage 1 -> no RAM write, all outputs return to their reset values, and a subsequent load of that address returns the old data.
